// File: rtl/vga_vram_arbiter.sv
// ---------------------------------------------------------------------------
// vga_vram_arbiter
//   Shares one single-port synchronous video RAM between the VGA scanout
//   (reads, absolute priority) and a pixel writer (buffered in a 4-entry
//   FIFO, drained only in cycles the display does not need the RAM).
//
// Ports
//   Clock, Reset     : rising-edge clock, asynchronous active-low reset
//   iPixelReq/Addr   : display read request and pixel address
//   oPixelData/Valid : colour returned two edges after the request edge
//   iWrReq/Addr/Data : writer push strobe, address and colour
//   oWrReady         : write FIFO not full
//   oMemAddr/We/WData: registered RAM command
//   iMemRData        : RAM read data, one cycle after the address
//   iClrStatus       : clears the sticky status flags
//   oOverflow        : sticky, a push was dropped on a full FIFO
//   oStarve          : sticky, writer denied STARVE_LIMIT consecutive cycles
//   oFifoLevel       : write FIFO occupancy 0..4
// ---------------------------------------------------------------------------
module vga_vram_arbiter #(
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned STARVE_LIMIT = 1023
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iPixelReq,
  input  logic [ADDR_W-1:0] iPixelAddr,
  output logic [DATA_W-1:0] oPixelData,
  output logic              oPixelValid,
  input  logic              iWrReq,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrReady,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemWe,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  input  logic              iClrStatus,
  output logic              oOverflow,
  output logic              oStarve,
  output logic [2:0]        oFifoLevel
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // write FIFO
  logic [ENT_W-1:0]  r_fifo [4];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [2:0]        r_level;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [ENT_W-1:0]  w_head;

  // RAM command registers
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  // read return pipeline
  logic              r_rd_pend;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;

  // status
  logic              r_overflow;
  logic              r_starve;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_cnt_next;
  logic              w_starve_set;

  assign w_full  = (r_level == 3'd4);
  assign w_empty = (r_level == 3'd0);
  assign w_head  = r_fifo[r_rptr];

  // Full is judged on the registered level, so a push meeting a full FIFO
  // is dropped even when the same edge pops an entry.
  assign w_push  = iWrReq && !w_full;
  assign w_drop  = iWrReq && w_full;

  // Grant decision for the coming cycle; a WR grant pops the head at the
  // same edge that launches the RAM write.
  always_comb begin
    w_state_next = ST_IDLE;
    w_pop        = 1'b0;
    if (iPixelReq) begin
      w_state_next = ST_RD;
    end else if (!w_empty) begin
      w_state_next = ST_WR;
      w_pop        = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Starvation counter: counts edges where data waits while the display
  // holds the RAM; the flag is raised only on the transition to the limit
  // so a clear while still saturated is not immediately undone.
  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    w_starve_set      = 1'b0;
    if (w_empty || w_pop) begin
      w_starve_cnt_next = '0;
    end else if (iPixelReq && (r_starve_cnt != LIMIT)) begin
      w_starve_cnt_next = r_starve_cnt + 1'b1;
      if (r_starve_cnt == (LIMIT - 1'b1)) begin
        w_starve_set = 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; emptiness is defined by the pointers.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {iWrAddr, iWrData};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      unique case (w_state_next)
        ST_RD: begin
          r_mem_addr <= iPixelAddr;
          r_mem_we   <= 1'b0;
        end
        ST_WR: begin
          r_mem_addr  <= w_head[ENT_W-1:DATA_W];
          r_mem_wdata <= w_head[DATA_W-1:0];
          r_mem_we    <= 1'b1;
        end
        default: begin
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  // RD granted after edge k -> RAM samples at k+1 -> data captured at k+2.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rd_pend   <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_rd_pend   <= (r_state == ST_RD);
      r_pix_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_pix_data <= iMemRData;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_overflow   <= 1'b0;
      r_starve     <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_cnt_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (iClrStatus) begin
        r_overflow <= 1'b0;
      end
      if (w_starve_set) begin
        r_starve <= 1'b1;
      end else if (iClrStatus) begin
        r_starve <= 1'b0;
      end
    end
  end

  assign oMemAddr    = r_mem_addr;
  assign oMemWe      = r_mem_we;
  assign oMemWData   = r_mem_wdata;
  assign oPixelValid = r_pix_valid;
  assign oPixelData  = r_pix_data;
  assign oOverflow   = r_overflow;
  assign oStarve     = r_starve;
  assign oFifoLevel  = r_level;
  assign oWrReady    = !w_full;

endmodule
